// File: rtl/cdt_frame_arbiter.sv
// Merges 18-word CDT event frames from four upstream ports onto one 16-bit
// valid/ready link, inserting a port-id word after each header.
module cdt_frame_arbiter #(
  parameter int NPORT       = 4,
  parameter int FRAME_WORDS = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in0,
  input  logic [15:0]      in1,
  input  logic [15:0]      in2,
  input  logic [15:0]      in3,
  input  logic [NPORT-1:0] port_en,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       err_cnt
);

  localparam logic [15:0] HDR_WORD = 16'hAAAA;
  localparam logic [15:0] TRL_WORD = 16'h5555;
  localparam logic [4:0]  LAST_IDX = 5'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {CAP_IDLE, CAP_CAPT, CAP_SKIP} cap_state_t;
  typedef enum logic [1:0] {ARB_ARB, ARB_HDR, ARB_SEND} arb_state_t;

  logic [15:0]      in_word [NPORT];
  logic [15:0]      rd_word [NPORT];
  logic [NPORT-1:0] full;
  logic [NPORT-1:0] clear_full;
  logic [NPORT-1:0] drop_evt;
  logic [NPORT-1:0] err_evt;
  logic [4:0]       rd_addr;

  assign in_word[0] = in0;
  assign in_word[1] = in1;
  assign in_word[2] = in2;
  assign in_word[3] = in3;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : gen_port
      cap_state_t  cap_state_reg, cap_state_next;
      logic [4:0]  idx_reg, idx_next;
      logic        full_reg;
      logic        wr_en;
      logic        set_full;
      logic        drop_l;
      logic        err_l;
      logic        full_eff;
      logic [15:0] rd_word_reg;
      logic [15:0] mem [FRAME_WORDS];

      // A flag being cleared by the arbiter on this edge already counts as free.
      assign full_eff    = full_reg & ~clear_full[gi];
      assign full[gi]    = full_reg;
      assign drop_evt[gi] = drop_l;
      assign err_evt[gi]  = err_l;
      assign rd_word[gi]  = rd_word_reg;

      always_comb begin
        cap_state_next = cap_state_reg;
        idx_next       = idx_reg;
        wr_en          = 1'b0;
        set_full       = 1'b0;
        drop_l         = 1'b0;
        err_l          = 1'b0;
        case (cap_state_reg)
          CAP_IDLE: begin
            if (in_word[gi] == HDR_WORD && port_en[gi]) begin
              idx_next = 5'd1;
              if (full_eff) begin
                drop_l         = 1'b1;
                cap_state_next = CAP_SKIP;
              end else begin
                wr_en          = 1'b1;
                cap_state_next = CAP_CAPT;
              end
            end
          end
          CAP_CAPT: begin
            wr_en = 1'b1;
            if (idx_reg == LAST_IDX) begin
              idx_next       = 5'd0;
              cap_state_next = CAP_IDLE;
              if (in_word[gi] == TRL_WORD) set_full = 1'b1;
              else                         err_l    = 1'b1;
            end else begin
              idx_next = idx_reg + 5'd1;
            end
          end
          CAP_SKIP: begin
            if (idx_reg == LAST_IDX) begin
              idx_next       = 5'd0;
              cap_state_next = CAP_IDLE;
            end else begin
              idx_next = idx_reg + 5'd1;
            end
          end
          default: begin
            idx_next       = 5'd0;
            cap_state_next = CAP_IDLE;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cap_state_reg <= CAP_IDLE;
          idx_reg       <= 5'd0;
          full_reg      <= 1'b0;
        end else begin
          cap_state_reg <= cap_state_next;
          idx_reg       <= idx_next;
          if (set_full)            full_reg <= 1'b1;
          else if (clear_full[gi]) full_reg <= 1'b0;
        end
      end

      // Frame buffer: idx_reg is 0 in IDLE, so the header lands at index 0.
      always_ff @(posedge clk) begin
        if (wr_en) mem[idx_reg] <= in_word[gi];
        rd_word_reg <= mem[rd_addr];
      end
    end
  endgenerate

  arb_state_t arb_state_reg, arb_state_next;
  logic [1:0] grant_reg, grant_next;
  logic [1:0] last_grant_reg, last_grant_next;
  logic       id_phase_reg, id_phase_next;
  logic [4:0] send_idx_reg, send_idx_next;
  logic       found;
  logic [1:0] pick;
  logic       xfer;

  assign xfer = out_valid & out_ready;
  assign busy = (|full) | (arb_state_reg != ARB_ARB);

  always_comb begin
    found = 1'b0;
    pick  = grant_reg;
    for (int k = 1; k <= NPORT; k++) begin
      if (!found && full[last_grant_reg + 2'(k)]) begin
        found = 1'b1;
        pick  = last_grant_reg + 2'(k);
      end
    end
  end

  // rd_addr is the address of the word shown next cycle (registered RAM read).
  always_comb begin
    arb_state_next  = arb_state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    id_phase_next   = id_phase_reg;
    send_idx_next   = send_idx_reg;
    clear_full      = '0;
    rd_addr         = 5'd1;
    out_valid       = 1'b0;
    out_data        = 16'h0000;
    case (arb_state_reg)
      ARB_ARB: begin
        if (found) begin
          grant_next     = pick;
          id_phase_next  = 1'b0;
          arb_state_next = ARB_HDR;
        end
      end
      ARB_HDR: begin
        out_valid = 1'b1;
        out_data  = id_phase_reg ? {14'b0, grant_reg} : HDR_WORD;
        if (xfer) begin
          if (!id_phase_reg) begin
            id_phase_next = 1'b1;
          end else begin
            send_idx_next  = 5'd1;
            arb_state_next = ARB_SEND;
          end
        end
      end
      ARB_SEND: begin
        out_valid = 1'b1;
        out_data  = rd_word[grant_reg];
        rd_addr   = send_idx_reg;
        if (xfer) begin
          if (send_idx_reg == LAST_IDX) begin
            clear_full[grant_reg] = 1'b1;
            last_grant_next       = grant_reg;
            arb_state_next        = ARB_ARB;
          end else begin
            send_idx_next = send_idx_reg + 5'd1;
            rd_addr       = send_idx_reg + 5'd1;
          end
        end
      end
      default: arb_state_next = ARB_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state_reg  <= ARB_ARB;
      grant_reg      <= 2'd0;
      last_grant_reg <= 2'd3;
      id_phase_reg   <= 1'b0;
      send_idx_reg   <= 5'd1;
    end else begin
      arb_state_reg  <= arb_state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      id_phase_reg   <= id_phase_next;
      send_idx_reg   <= send_idx_next;
    end
  end

  logic [8:0] drop_sum, err_sum;
  logic [7:0] drop_cnt_reg, err_cnt_reg;

  assign drop_sum = {1'b0, drop_cnt_reg} + 9'($countones(drop_evt));
  assign err_sum  = {1'b0, err_cnt_reg} + 9'($countones(err_evt));
  assign drop_cnt = drop_cnt_reg;
  assign err_cnt  = err_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_reg <= 8'd0;
      err_cnt_reg  <= 8'd0;
    end else begin
      drop_cnt_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      err_cnt_reg  <= err_sum[8]  ? 8'hFF : err_sum[7:0];
    end
  end

endmodule
